// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// Used by the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned DefOversample = 16;
    localparam int unsigned DefDataBits   = 8;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop,
        RxWaitIdle
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Line-side and result signals of the UART receiver.
// slave = receiver, master = whoever drives the line and consumes results.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DefDataBits
);

    logic                 os_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport slave (
        input  os_tick,
        input  rx,
        output data_out,
        output valid,
        output frame_err,
        output parity_err,
        output busy
    );

    modport master (
        output os_tick,
        output rx,
        input  data_out,
        input  valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to ResetVal so reset release looks like a steady line.
module uart_sync #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {2{ResetVal}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with mid-bit sampling, glitch rejection and break handling.
// Optional even parity via `define UART_RX_PARITY_EN; default build is start + data + stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = DefOversample,
    parameter int unsigned DATA_BITS  = DefDataBits
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS);

    localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickFull = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

    logic rx_s;

    uart_sync #(
        .ResetVal (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.rx),
        .q_o (rx_s)
    );

    rx_state_e            state_q, state_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 bit_end;

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    logic par_bad_q, par_bad_d;
`endif

    assign bit_end = (tick_q == TickFull);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        if (bus.os_tick) begin
            unique case (state_q)
                RxIdle: begin
                    if (!rx_s) begin
                        state_d = RxStart;
                        tick_d  = '0;
                    end
                end
                RxStart: begin
                    // Half a bit in: a line back high means the edge was a glitch.
                    if (tick_q == TickHalf) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? RxIdle : RxData;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                RxData: begin
                    if (bit_end) begin
                        tick_d  = '0;
                        bit_d   = bit_q + 1'b1;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                            state_d = RxParity;
`else
                            state_d = RxStop;
`endif
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                RxParity: begin
                    if (bit_end) begin
                        tick_d    = '0;
                        par_bad_d = rx_s ^ (^shift_q);
                        state_d   = RxStop;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`endif
                RxStop: begin
                    if (bit_end) begin
                        tick_d = '0;
                        dout_d = shift_q;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            perr_d  = par_bad_q;
                            valid_d = !par_bad_q;
`else
                            valid_d = 1'b1;
`endif
                            state_d = RxIdle;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = RxWaitIdle;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                RxWaitIdle: begin
                    if (rx_s) begin
                        state_d = RxIdle;
                    end
                end
                default: state_d = RxIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RxIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
        end
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.data_out  = dout_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != RxIdle);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, os_tick pulses per bit period (even, >=8).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..8).
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port os_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate.
REQ-006 SHALL have port rx  input  1  serial line, asynchronous, idle high.
REQ-007 SHALL have port data_out  output  DATA_BITS  last received word, LSB = first bit on the line.
REQ-008 SHALL have port valid  output  1  one-clk pulse: data_out holds a good frame.
REQ-009 SHALL have port frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-010 SHALL have port parity_err  output  1  one-clk pulse: parity mismatch (tied 0 without the macro in REQ-031).
REQ-011 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any use; that latency is excluded from all counts below.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; the tick counter and bit counter advance only on os_tick.
REQ-014 IDLE: a synchronized rx low on an os_tick SHALL move the block to START and clear the tick counter.
REQ-015 START: after OVERSAMPLE/2 ticks, rx high SHALL abort to IDLE (glitch) with no output pulse; rx low SHALL move the block to DATA with the tick counter cleared.
REQ-016 DATA: every OVERSAMPLE ticks (mid-bit) SHALL shift rx into the shift register LSB-first; after DATA_BITS samples, go to PARITY if enabled, else STOP.
REQ-017 PARITY: SHALL sample one bit OVERSAMPLE ticks after the last data sample and compare it with even parity over the data bits.
REQ-018 STOP: SHALL sample OVERSAMPLE ticks after the previous sample; data_out SHALL be loaded from the shift register in the same clk.
REQ-019 Stop high and no parity error: valid=1 for exactly one clk; next state IDLE.
REQ-020 Stop high and parity error: parity_err=1 for one clk, valid=0; next state IDLE.
REQ-021 Stop low: frame_err=1 for one clk, valid=0, parity_err suppressed; next state WAIT_IDLE.
REQ-022 WAIT_IDLE: SHALL remain there until rx is sampled high on an os_tick, then go to IDLE (break handling; no new start accepted while low).
REQ-023 valid, frame_err and parity_err SHALL be mutually exclusive and SHALL never exceed one clk in width.
REQ-024 data_out SHALL hold its value until the next STOP sample; it SHALL NOT change during reception.
REQ-025 A new start edge SHALL be accepted on the first os_tick after returning to IDLE (back-to-back frames, no gap required).
REQ-026 os_tick low SHALL freeze all counters and the state; the output pulses are not ticked and last one clk.

Reset
REQ-027 rst SHALL force state=IDLE, clear both counters and the shift register, and set data_out=0, valid=0, frame_err=0, parity_err=0, busy=0.
REQ-028 Synchronizer flops SHALL reset to 1 (line idle) so that release of reset causes no false start.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame with no output pulse; reception restarts only on a new falling edge after release.

Configuration
REQ-030 Macro UART_RX_PARITY_EN SHALL be the only compile option.
REQ-031 With UART_RX_PARITY_EN defined, the frame is start + DATA_BITS + even parity + stop, and parity_err is live; without it, the frame is 8N1-style (no PARITY state), and parity_err is constant 0.

Structure
REQ-032 Package uart_pkg SHALL hold the rx state enum and the default OVERSAMPLE/DATA_BITS constants, shared with the transmitter.
REQ-033 The synchronizer SHALL be sub-module uart_sync (2-flop, reset value parameterised).

Verification
REQ-034 Send 0xA5 8N1 at 16x: data_out=0xA5, valid a single clk pulse near mid-stop, frame_err=0, busy low after.
REQ-035 rx low for 4 os_ticks then high: no valid/frame_err, busy returns 0 after 8 ticks.
REQ-036 Send 0x3C with stop bit forced low for 2 bit times: frame_err pulse, no valid; next frame 0x55 received correctly after rx high.
REQ-037 Back-to-back 0x00 then 0xFF with no idle gap: two valid pulses, data_out 0x00 then 0xFF.
REQ-038 Assert rst during bit 4 of 0x81: all outputs 0 immediately; next full frame 0x7E yields valid with 0x7E.
REQ-039 With UART_RX_PARITY_EN: 0x03 with parity bit 1: parity_err pulse, valid=0; 0x03 with parity bit 0: valid, data_out=0x03.
